// File: rtl/ahb_mtx_pkg.sv
// rtl/ahb_mtx_pkg.sv - shared AHB encodings for the bus matrix
package ahb_mtx_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

endpackage

// File: rtl/ahb_mtx_input_stage.sv
// rtl/ahb_mtx_input_stage.sv - per-master address-phase hold and request stage
module ahb_mtx_input_stage
   import ahb_mtx_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int PROT_W = 4
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSELS,
   input  logic              HWRITES,
   input  logic              HMASTLOCKS,
   input  logic              HREADYS,
   input  logic [ADDR_W-1:0] HADDRS,
   input  logic [1:0]        HTRANSS,
   input  logic [2:0]        HSIZES,
   input  logic [2:0]        HBURSTS,
   input  logic [PROT_W-1:0] HPROTS,
   output logic              HREADYOUTS,
   output logic [1:0]        HRESPS,
   output logic              sel_o,
   output logic              write_o,
   output logic              mastlock_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [1:0]        trans_o,
   output logic [2:0]        size_o,
   output logic [2:0]        burst_o,
   output logic [PROT_W-1:0] prot_o,
   output logic              held_tran_o,
   input  logic              addr_granted_i,
   input  logic              hreadym_i,
   input  logic              data_valid_i,
   input  logic              hready_data_i,
   input  logic [1:0]        hresp_data_i
);

   logic              hold_sel;
   logic              hold_write;
   logic              hold_lock;
   logic [ADDR_W-1:0] hold_addr;
   logic [1:0]        hold_trans;
   logic [2:0]        hold_size;
   logic [2:0]        hold_burst;
   logic [PROT_W-1:0] hold_prot;
   logic              hold_granted;
   logic              held_tran;

   logic              tran_pend;
   logic              grant_now;

   assign tran_pend = HSELS & HREADYS & HTRANSS[1];
   assign grant_now = addr_granted_i & hreadym_i;

   // Capture the live address phase whenever the master's bus advances;
   // remember whether the port already owned an output stage at that point.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hold_sel     <= 1'b0;
         hold_write   <= 1'b0;
         hold_lock    <= 1'b0;
         hold_addr    <= '0;
         hold_trans   <= HTRANS_IDLE;
         hold_size    <= 3'b000;
         hold_burst   <= HBURST_SINGLE;
         hold_prot    <= '0;
         hold_granted <= 1'b0;
      end else if (HREADYS) begin
         hold_sel     <= HSELS;
         hold_write   <= HWRITES;
         hold_lock    <= HMASTLOCKS;
         hold_addr    <= HADDRS;
         hold_trans   <= HTRANSS;
         hold_size    <= HSIZES;
         hold_burst   <= HBURSTS;
         hold_prot    <= HPROTS;
         hold_granted <= addr_granted_i;
      end
   end

   // Pending flag: set by an ungranted request, cleared by the grant that
   // takes it or by the master moving on; a same-cycle grant wins.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         held_tran <= 1'b0;
      end else if (tran_pend && !grant_now) begin
         held_tran <= 1'b1;
      end else if (held_tran && grant_now) begin
         held_tran <= 1'b0;
      end else if (HREADYS) begin
         held_tran <= 1'b0;
      end
   end

   // Present the held transfer while pending, else pass the live bus; a SEQ
   // that lost its arbitration must restart as NONSEQ at the new owner.
   always_comb begin
      sel_o      = HSELS;
      write_o    = HWRITES;
      mastlock_o = HMASTLOCKS;
      addr_o     = HADDRS;
      trans_o    = HTRANSS;
      size_o     = HSIZES;
      burst_o    = HBURSTS;
      prot_o     = HPROTS;
      if (held_tran) begin
         sel_o      = 1'b1;
         write_o    = hold_write;
         mastlock_o = hold_lock;
         addr_o     = hold_addr;
         trans_o    = hold_trans;
         size_o     = hold_size;
         burst_o    = hold_burst;
         prot_o     = hold_prot;
         if (hold_trans == HTRANS_SEQ && !hold_granted) begin
            trans_o = HTRANS_NONSEQ;
         end
      end
   end

   // Master handshake: a pending address phase stalls the master unless the
   // data phase is terminating with ERROR.
   always_comb begin
      HRESPS     = HRESP_OKAY;
      HREADYOUTS = ~held_tran;
      if (data_valid_i) begin
         HRESPS     = hresp_data_i;
         HREADYOUTS = hready_data_i & (~held_tran | (hresp_data_i == HRESP_ERROR));
      end
   end

   assign held_tran_o = held_tran;

   // hold_sel is captured for completeness of the address phase; a held
   // transfer is always selected so it does not reach the outputs.
   logic unused_hold_sel;
   assign unused_hold_sel = hold_sel;

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// tb/tb_ahb_mtx_input_stage.sv - self-checking bench for ahb_mtx_input_stage
module tb_ahb_mtx_input_stage;
   import ahb_mtx_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSELS, HWRITES, HMASTLOCKS, HREADYS;
   logic [31:0] HADDRS;
   logic [1:0]  HTRANSS;
   logic [2:0]  HSIZES, HBURSTS;
   logic [3:0]  HPROTS;
   logic        HREADYOUTS;
   logic [1:0]  HRESPS;
   logic        sel_o, write_o, mastlock_o;
   logic [31:0] addr_o;
   logic [1:0]  trans_o;
   logic [2:0]  size_o, burst_o;
   logic [3:0]  prot_o;
   logic        held_tran_o;
   logic        addr_granted_i, hreadym_i, data_valid_i, hready_data_i;
   logic [1:0]  hresp_data_i;

   logic        tie_ready;
   logic        hreadys_drv;
   assign HREADYS = tie_ready ? HREADYOUTS : hreadys_drv;

   int tests = 0;
   int fails = 0;

   always #5 HCLK = ~HCLK;

   ahb_mtx_input_stage #(.ADDR_W(32), .PROT_W(4)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .HSELS(HSELS), .HWRITES(HWRITES), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
      .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
      .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
      .sel_o(sel_o), .write_o(write_o), .mastlock_o(mastlock_o),
      .addr_o(addr_o), .trans_o(trans_o), .size_o(size_o), .burst_o(burst_o), .prot_o(prot_o),
      .held_tran_o(held_tran_o),
      .addr_granted_i(addr_granted_i), .hreadym_i(hreadym_i),
      .data_valid_i(data_valid_i), .hready_data_i(hready_data_i), .hresp_data_i(hresp_data_i)
   );

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic [31:0] addr;
      logic        rdy;
      logic        grant;
      logic        hrm;
      logic        dv;
      logic        hrd;
      logic [1:0]  resp;
      logic        e_held;
      logic        e_hro;
      logic [1:0]  e_resp;
      logic [31:0] e_addr;
      logic [1:0]  e_trans;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic sel, logic [1:0] trans, logic [31:0] addr, logic rdy,
                               logic grant, logic hrm, logic dv, logic hrd, logic [1:0] resp,
                               logic e_held, logic e_hro, logic [1:0] e_resp,
                               logic [31:0] e_addr, logic [1:0] e_trans);
      vec_t v;
      v.sel = sel; v.trans = trans; v.addr = addr; v.rdy = rdy; v.grant = grant;
      v.hrm = hrm; v.dv = dv; v.hrd = hrd; v.resp = resp;
      v.e_held = e_held; v.e_hro = e_hro; v.e_resp = e_resp;
      v.e_addr = e_addr; v.e_trans = e_trans;
      return v;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: at most one transfer waits for arbitration.
   typedef struct packed {
      logic        sel, write, lock;
      logic [31:0] addr;
      logic [1:0]  trans;
      logic [2:0]  size, burst;
      logic [3:0]  prot;
   } ap_t;

   typedef struct packed {
      ap_t  ap;
      logic owned_at_issue;
   } pend_t;

   pend_t waiting[$];

   function automatic ap_t live_ap();
      ap_t a;
      a.sel = HSELS; a.write = HWRITES; a.lock = HMASTLOCKS; a.addr = HADDRS;
      a.trans = HTRANSS; a.size = HSIZES; a.burst = HBURSTS; a.prot = HPROTS;
      return a;
   endfunction

   function automatic logic model_hro();
      if (data_valid_i)
         return hready_data_i && (waiting.size() == 0 || hresp_data_i == HRESP_ERROR);
      return waiting.size() == 0;
   endfunction

   function automatic logic [63:0] model_out();
      ap_t   e;
      logic [1:0] r;
      if (waiting.size() != 0) begin
         e = waiting[0].ap;
         e.sel = 1'b1;
         if (e.trans == HTRANS_SEQ && !waiting[0].owned_at_issue) e.trans = HTRANS_NONSEQ;
      end else begin
         e = live_ap();
      end
      r = data_valid_i ? hresp_data_i : HRESP_OKAY;
      return {13'd0, waiting.size() != 0, model_hro(), r, e};
   endfunction

   function automatic logic [63:0] dut_out();
      return {13'd0, held_tran_o, HREADYOUTS, HRESPS, sel_o, write_o, mastlock_o, addr_o,
              trans_o, size_o, burst_o, prot_o};
   endfunction

   task automatic model_clock(logic rdy);
      logic wants, taken;
      pend_t p;
      wants = HSELS && rdy && HTRANSS[1];
      taken = addr_granted_i && hreadym_i;
      if (wants && !taken) begin
         p.ap = live_ap();
         p.owned_at_issue = addr_granted_i;
         waiting.delete();
         waiting.push_back(p);
      end else if (taken || rdy) begin
         waiting.delete();
      end
   endtask

   task automatic apply_vec(vec_t v);
      HSELS = v.sel; HTRANSS = v.trans; HADDRS = v.addr; hreadys_drv = v.rdy;
      addr_granted_i = v.grant; hreadym_i = v.hrm; data_valid_i = v.dv;
      hready_data_i = v.hrd; hresp_data_i = v.resp;
   endtask

   initial begin
      logic [63:0] exp_o;
      logic        rdy_model;
      int          i;

      HRESETn = 1'b0; tie_ready = 1'b0; hreadys_drv = 1'b1;
      HSELS = 1'b1; HWRITES = 1'b0; HMASTLOCKS = 1'b0; HADDRS = 32'h2000_0000;
      HTRANSS = HTRANS_NONSEQ; HSIZES = 3'b010; HBURSTS = HBURST_INCR4; HPROTS = 4'h3;
      addr_granted_i = 1'b0; hreadym_i = 1'b0; data_valid_i = 1'b0;
      hready_data_i = 1'b0; hresp_data_i = HRESP_OKAY;

      repeat (2) @(negedge HCLK);
      #1;
      check("reset_state", {held_tran_o, HREADYOUTS, HRESPS, addr_o, trans_o},
            {1'b0, 1'b1, HRESP_OKAY, 32'h2000_0000, HTRANS_NONSEQ});

      // hold, grant, release
      vecs.push_back(mk(1, HTRANS_NONSEQ, 32'h2000_0000, 1, 0, 0, 0, 0, HRESP_OKAY, 0, 1, HRESP_OKAY, 32'h2000_0000, HTRANS_NONSEQ));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 32'h3000_0000, 0, 0, 0, 0, 0, HRESP_OKAY, 1, 0, HRESP_OKAY, 32'h2000_0000, HTRANS_NONSEQ));
      vecs.push_back(mk(1, HTRANS_NONSEQ, 32'h3000_0000, 0, 1, 1, 1, 1, HRESP_OKAY, 1, 0, HRESP_OKAY, 32'h2000_0000, HTRANS_NONSEQ));
      vecs.push_back(mk(1, HTRANS_IDLE,   32'h3000_0000, 0, 1, 1, 1, 0, HRESP_OKAY, 0, 0, HRESP_OKAY, 32'h3000_0000, HTRANS_IDLE));
      vecs.push_back(mk(1, HTRANS_IDLE,   32'h3000_0000, 1, 1, 1, 1, 1, HRESP_OKAY, 0, 1, HRESP_OKAY, 32'h3000_0000, HTRANS_IDLE));
      // already-granted INCR4 burst
      vecs.push_back(mk(1, HTRANS_NONSEQ, 32'h0000_0100, 1, 1, 1, 0, 0, HRESP_OKAY, 0, 1, HRESP_OKAY, 32'h0000_0100, HTRANS_NONSEQ));
      vecs.push_back(mk(1, HTRANS_SEQ,    32'h0000_0104, 1, 1, 1, 1, 1, HRESP_OKAY, 0, 1, HRESP_OKAY, 32'h0000_0104, HTRANS_SEQ));
      vecs.push_back(mk(1, HTRANS_SEQ,    32'h0000_0108, 0, 1, 1, 1, 0, HRESP_OKAY, 0, 0, HRESP_OKAY, 32'h0000_0108, HTRANS_SEQ));
      vecs.push_back(mk(1, HTRANS_SEQ,    32'h0000_0108, 1, 1, 1, 1, 1, HRESP_OKAY, 0, 1, HRESP_OKAY, 32'h0000_0108, HTRANS_SEQ));
      vecs.push_back(mk(1, HTRANS_SEQ,    32'h0000_010C, 1, 1, 1, 1, 1, HRESP_OKAY, 0, 1, HRESP_OKAY, 32'h0000_010C, HTRANS_SEQ));
      // ungranted SEQ becomes NONSEQ, then ERROR terminates it
      vecs.push_back(mk(1, HTRANS_SEQ,    32'h0000_0110, 1, 0, 0, 1, 1, HRESP_OKAY, 0, 1, HRESP_OKAY, 32'h0000_0110, HTRANS_SEQ));
      vecs.push_back(mk(1, HTRANS_SEQ,    32'h0000_0110, 0, 0, 0, 0, 0, HRESP_OKAY, 1, 0, HRESP_OKAY, 32'h0000_0110, HTRANS_NONSEQ));
      vecs.push_back(mk(1, HTRANS_SEQ,    32'h0000_0110, 0, 0, 0, 1, 0, HRESP_ERROR, 1, 0, HRESP_ERROR, 32'h0000_0110, HTRANS_NONSEQ));
      vecs.push_back(mk(1, HTRANS_IDLE,   32'h0000_0110, 1, 0, 0, 1, 1, HRESP_ERROR, 1, 1, HRESP_ERROR, 32'h0000_0110, HTRANS_NONSEQ));
      vecs.push_back(mk(1, HTRANS_IDLE,   32'h0000_0110, 1, 0, 0, 0, 0, HRESP_OKAY, 0, 1, HRESP_OKAY, 32'h0000_0110, HTRANS_IDLE));
      // owned port stalled by HREADYM keeps SEQ
      vecs.push_back(mk(1, HTRANS_SEQ,    32'h0000_0200, 1, 1, 0, 0, 0, HRESP_OKAY, 0, 1, HRESP_OKAY, 32'h0000_0200, HTRANS_SEQ));
      vecs.push_back(mk(1, HTRANS_SEQ,    32'h0000_0204, 0, 1, 0, 0, 0, HRESP_OKAY, 1, 0, HRESP_OKAY, 32'h0000_0200, HTRANS_SEQ));
      vecs.push_back(mk(1, HTRANS_SEQ,    32'h0000_0204, 0, 1, 1, 0, 0, HRESP_OKAY, 1, 0, HRESP_OKAY, 32'h0000_0200, HTRANS_SEQ));
      vecs.push_back(mk(1, HTRANS_IDLE,   32'h0000_0204, 1, 1, 1, 0, 0, HRESP_OKAY, 0, 1, HRESP_OKAY, 32'h0000_0204, HTRANS_IDLE));
      // unselected and BUSY are never held
      vecs.push_back(mk(0, HTRANS_NONSEQ, 32'h0000_0300, 1, 0, 0, 0, 0, HRESP_OKAY, 0, 1, HRESP_OKAY, 32'h0000_0300, HTRANS_NONSEQ));
      vecs.push_back(mk(1, HTRANS_BUSY,   32'h0000_0304, 1, 0, 0, 0, 0, HRESP_OKAY, 0, 1, HRESP_OKAY, 32'h0000_0304, HTRANS_BUSY));
      vecs.push_back(mk(1, HTRANS_IDLE,   32'h0000_0308, 1, 0, 0, 0, 0, HRESP_OKAY, 0, 1, HRESP_OKAY, 32'h0000_0308, HTRANS_IDLE));

      HRESETn = 1'b1;
      foreach (vecs[k]) begin
         apply_vec(vecs[k]);
         #1;
         check($sformatf("vec%0d", k), {held_tran_o, HREADYOUTS, HRESPS, addr_o, trans_o},
               {vecs[k].e_held, vecs[k].e_hro, vecs[k].e_resp, vecs[k].e_addr, vecs[k].e_trans});
         @(negedge HCLK);
      end

      // asynchronous reset while holding
      apply_vec(mk(1, HTRANS_NONSEQ, 32'h0000_0400, 1, 0, 0, 0, 0, HRESP_OKAY, 0, 0, 0, 0, 0));
      @(negedge HCLK);
      hreadys_drv = 1'b0; HADDRS = 32'h0000_0500;
      #1;
      check("hold_before_reset", {held_tran_o, HREADYOUTS, addr_o}, {1'b1, 1'b0, 32'h0000_0400});
      @(posedge HCLK);
      #2;
      HRESETn = 1'b0;
      #1;
      check("async_reset", {held_tran_o, HREADYOUTS, HRESPS, addr_o},
            {1'b0, 1'b1, HRESP_OKAY, 32'h0000_0500});
      waiting.delete();
      @(negedge HCLK);
      HRESETn = 1'b1;

      // randomized traffic against the model
      for (i = 0; i < 400; i++) begin
         tie_ready = ($urandom_range(0, 1) == 1);
         hreadys_drv = $urandom_range(0, 1);
         HSELS = ($urandom_range(0, 3) != 0);
         HWRITES = $urandom_range(0, 1);
         HMASTLOCKS = $urandom_range(0, 1);
         HADDRS = $urandom;
         HTRANSS = $urandom_range(0, 3);
         HSIZES = $urandom_range(0, 7);
         HBURSTS = $urandom_range(0, 7);
         HPROTS = $urandom_range(0, 15);
         addr_granted_i = $urandom_range(0, 1);
         hreadym_i = $urandom_range(0, 1);
         data_valid_i = $urandom_range(0, 1);
         hready_data_i = $urandom_range(0, 1);
         hresp_data_i = {1'b0, 1'($urandom_range(0, 1))};
         #1;
         exp_o = model_out();
         check($sformatf("rand%0d", i), dut_out(), exp_o);
         rdy_model = tie_ready ? model_hro() : hreadys_drv;
         @(posedge HCLK);
         model_clock(rdy_model);
         @(negedge HCLK);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
